// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch master and a data master.
// Latency: zero added cycles; grant and response are combinational pass-throughs, one-cycle bubble between transactions.
// Backpressure: one outstanding transaction; while busy both grants are held low and new requests wait.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin arbitration; default is data-over-instruction priority).
// Ports:
//   CLK, RES                      clock (rising edge), synchronous active-low reset
//   instr_req/addr/gnt/r_valid/rdata          fetch master
//   data_req/addr/write_enable/wdata/gnt/r_valid/rdata   data master
//   mem_req/addr/we/wdata/gnt/r_valid/rdata   memory slave
//   err                           one-cycle pulse when the response watchdog aborts a transaction
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_gnt,
  output logic              instr_r_valid,
  output logic [DATA_W-1:0] instr_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_write_enable,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_r_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_r_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             abort;
  logic             timeout_hit;
  logic             win_d, win_i;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_d = 1: data wins a tie; flips to the other master after every grant.
  logic ptr_d;
  assign win_d = data_req & (~instr_req | ptr_d);
`else
  assign win_d = data_req;
`endif
  assign win_i = instr_req & ~win_d;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

  // Response data is never gated; only the valids identify the owner.
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;
  assign err         = err_q;

  always_comb begin
    state_nxt     = state;
    abort         = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    instr_gnt     = 1'b0;
    data_gnt      = 1'b0;
    instr_r_valid = 1'b0;
    data_r_valid  = 1'b0;
    // Handshake outputs are held low while reset is asserted so nothing leaks
    // out of an abandoned transaction.
    if (RES) begin
      case (state)
        IDLE: begin
          // mem_r_valid here is stale or stray and is dropped.
          if (win_d) begin
            mem_req   = 1'b1;
            mem_addr  = data_addr;
            mem_we    = data_write_enable;
            mem_wdata = data_wdata;
            data_gnt  = mem_gnt;
            if (mem_gnt) state_nxt = BUSY_D;
          end else if (win_i) begin
            mem_req   = 1'b1;
            mem_addr  = instr_addr;
            instr_gnt = mem_gnt;
            if (mem_gnt) state_nxt = BUSY_I;
          end
        end
        BUSY_I: begin
          instr_r_valid = mem_r_valid;
          if (mem_r_valid) begin
            state_nxt = IDLE;
          end else if (timeout_hit) begin
            state_nxt = IDLE;
            abort     = 1'b1;
          end
        end
        BUSY_D: begin
          data_r_valid = mem_r_valid;
          if (mem_r_valid) begin
            state_nxt = IDLE;
          end else if (timeout_hit) begin
            state_nxt = IDLE;
            abort     = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= abort;
      // Held at zero in IDLE, so a grant always starts the watchdog from zero.
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK) begin
    if (!RES)          ptr_d <= 1'b0;
    else if (data_gnt)  ptr_d <= 1'b0;
    else if (instr_gnt) ptr_d <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard for grants and responses.
// Latency: expected grants/responses are queued by the stimulus and popped by a negedge monitor.
// Backpressure: the bench plays the memory slave directly via mem_gnt / mem_r_valid.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RES;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt, instr_r_valid;
  logic [DW-1:0] instr_rdata;
  logic          data_req;
  logic [AW-1:0] data_addr;
  logic          data_write_enable;
  logic [DW-1:0] data_wdata;
  logic          data_gnt, data_r_valid;
  logic [DW-1:0] data_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_r_valid;
  logic [DW-1:0] mem_rdata;
  logic          err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RES(RES),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_r_valid(instr_r_valid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_write_enable(data_write_enable),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_r_valid(data_r_valid),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_r_valid(mem_r_valid), .mem_rdata(mem_rdata),
    .err(err)
  );

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] dat;
  } resp_t;

  logic  exp_g[$];   // 1 = data grant expected, 0 = fetch grant expected
  resp_t exp_r[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every grant and every forwarded response must match the head of its queue.
  always @(negedge CLK) begin
    logic  g;
    resp_t r;
    if (instr_gnt || data_gnt) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_gnt", {instr_gnt, data_gnt}, 2'b00);
      end else begin
        g = exp_g.pop_front();
        chk("gnt", {instr_gnt, data_gnt}, {~g, g});
      end
    end
    if (instr_r_valid || data_r_valid) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_rvalid", {instr_r_valid, data_r_valid}, 2'b00);
      end else begin
        r = exp_r.pop_front();
        chk("rvalid", {instr_r_valid, data_r_valid}, {~r.is_d, r.is_d});
        chk("rdata", r.is_d ? data_rdata : instr_rdata, r.dat);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_addr = '0; data_write_enable = 1'b0; data_wdata = '0;
    mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n_err;
    int first_err;
    RES = 1'b0;
    idle_inputs();

    // ---------------- reset state ----------------
    step(); step();
    @(negedge CLK);
    chk("reset_outputs",
        {mem_req, mem_addr, mem_we, mem_wdata, instr_gnt, data_gnt,
         instr_r_valid, data_r_valid, err, instr_rdata, data_rdata}, '0);
    step();
    RES = 1'b1;
    step();
    @(negedge CLK);
    chk("idle_outputs", {mem_req, mem_addr, mem_we, mem_wdata, err}, '0);

    // ---------------- fetch only ----------------
    step();
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
    exp_g.push_back(1'b0);
    exp_r.push_back('{is_d: 1'b0, dat: 32'h0050_0093});
    @(negedge CLK);
    chk("fetch_mem_req_addr_we", {mem_req, mem_addr, mem_we, mem_wdata}, {1'b1, 32'h100, 1'b0, 32'h0});
    step();
    instr_req = 1'b0; mem_gnt = 1'b0;
    step();
    mem_r_valid = 1'b1; mem_rdata = 32'h0050_0093;
    step();
    idle_inputs();

    // ---------------- contention: data first, fetch after a bubble ----------------
    step();
    instr_req = 1'b1; instr_addr = 32'h104;
    data_req = 1'b1; data_addr = 32'h200; data_write_enable = 1'b0; mem_gnt = 1'b1;
    exp_g.push_back(1'b1);
    @(negedge CLK);
    chk("contend_addr", mem_addr, 32'h200);
    step();
    data_req = 1'b0; mem_gnt = 1'b0;
    @(negedge CLK);
    chk("busy_blocks_req", {mem_req, instr_gnt}, 2'b00);
    step();
    mem_r_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    exp_r.push_back('{is_d: 1'b1, dat: 32'hDEAD_BEEF});
    @(negedge CLK);
    chk("no_gnt_in_rvalid_cycle", instr_gnt, 1'b0);
    step();
    // Grant one cycle after the response; a simultaneous IDLE r_valid is ignored.
    mem_gnt = 1'b1; mem_r_valid = 1'b1; mem_rdata = 32'h1111_1111;
    exp_g.push_back(1'b0);
    @(negedge CLK);
    chk("bubble_fetch_gnt", {instr_gnt, mem_addr}, {1'b1, 32'h104});
    step();
    instr_req = 1'b0; mem_gnt = 1'b0; mem_r_valid = 1'b1; mem_rdata = 32'h0000_0013;
    exp_r.push_back('{is_d: 1'b0, dat: 32'h0000_0013});
    step();
    idle_inputs();

    // ---------------- store ----------------
    step();
    data_req = 1'b1; data_write_enable = 1'b1; data_addr = 32'h300; data_wdata = 32'h1234_5678;
    mem_gnt = 1'b1;
    exp_g.push_back(1'b1);
    @(negedge CLK);
    chk("store_mem_fields", {mem_req, mem_addr, mem_we, mem_wdata}, {1'b1, 32'h300, 1'b1, 32'h1234_5678});
    step();
    idle_inputs();
    mem_r_valid = 1'b1; mem_rdata = 32'h0;
    exp_r.push_back('{is_d: 1'b1, dat: 32'h0});
    step();
    idle_inputs();

    // ---------------- watchdog ----------------
    // Grant in cycle 0; counter runs 0..TO over cycles 1..TO+1, err visible in cycle TO+2.
    step();
    data_req = 1'b1; data_addr = 32'h400; mem_gnt = 1'b1;
    exp_g.push_back(1'b1);
    n_err = 0;
    first_err = -1;
    for (int k = 1; k <= 14; k++) begin
      step();
      idle_inputs();
      if (k == TO + 3) mem_r_valid = 1'b1;   // late response after abort: must be dropped
      @(negedge CLK);
      if (err) begin
        n_err++;
        if (first_err < 0) first_err = k;
      end
    end
    chk("err_pulse_count", n_err, 1);
    chk("err_cycle", first_err, TO + 2);
    step();
    instr_req = 1'b1; instr_addr = 32'h180; mem_gnt = 1'b1;
    exp_g.push_back(1'b0);
    step();
    idle_inputs();
    mem_r_valid = 1'b1; mem_rdata = 32'hABCD_0001;
    exp_r.push_back('{is_d: 1'b0, dat: 32'hABCD_0001});
    step();
    idle_inputs();

    // ---------------- reset mid-transaction ----------------
    step();
    data_req = 1'b1; data_addr = 32'h500; mem_gnt = 1'b1;
    exp_g.push_back(1'b1);
    step();
    idle_inputs();
    step();
    RES = 1'b0; data_req = 1'b1; data_addr = 32'h504; mem_r_valid = 1'b1;
    @(negedge CLK);
    chk("outputs_in_reset_a",
        {mem_req, mem_addr, mem_we, mem_wdata, instr_gnt, data_gnt,
         instr_r_valid, data_r_valid, err}, '0);
    step();
    mem_r_valid = 1'b0;
    @(negedge CLK);
    chk("outputs_in_reset_b",
        {mem_req, mem_addr, mem_we, mem_wdata, instr_gnt, data_gnt,
         instr_r_valid, data_r_valid, err}, '0);
    step();
    RES = 1'b1; idle_inputs(); mem_r_valid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge CLK);
    chk("late_rvalid_dropped", data_r_valid, 1'b0);
    step();
    idle_inputs();
    data_req = 1'b1; data_addr = 32'h508; mem_gnt = 1'b1;
    exp_g.push_back(1'b1);
    step();
    idle_inputs();
    mem_r_valid = 1'b1; mem_rdata = 32'h0000_0055;
    exp_r.push_back('{is_d: 1'b1, dat: 32'h0000_0055});
    step();
    idle_inputs();

`ifdef ARB_ROUND_ROBIN_EN
    // ---------------- round-robin ----------------
    // A fetch first leaves the pointer preferring data, so the tie sequence is D, I, D, I.
    step();
    instr_req = 1'b1; instr_addr = 32'h1C0; mem_gnt = 1'b1;
    exp_g.push_back(1'b0);
    step();
    idle_inputs();
    mem_r_valid = 1'b1; mem_rdata = 32'h0000_00AA;
    exp_r.push_back('{is_d: 1'b0, dat: 32'h0000_00AA});
    for (int i = 0; i < 4; i++) begin
      step();
      idle_inputs();
      instr_req = 1'b1; instr_addr = 32'h200 + 32'(i);
      data_req = 1'b1; data_addr = 32'h600 + 32'(i); mem_gnt = 1'b1;
      exp_g.push_back(((i % 2) == 0) ? 1'b1 : 1'b0);
      step();
      mem_gnt = 1'b0; mem_r_valid = 1'b1; mem_rdata = 32'hC0DE_0000 + 32'(i);
      exp_r.push_back('{is_d: ((i % 2) == 0) ? 1'b1 : 1'b0, dat: 32'hC0DE_0000 + 32'(i)});
    end
    step();
    idle_inputs();
`endif

    step(); step(); step();
    chk("grant_queue_drained", exp_g.size(), 0);
    chk("resp_queue_drained", exp_r.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-slave arbiter that shares one memory port between the control unit's instruction-fetch interface and its data-access interface. It uses the same req/gnt/r_valid handshake on all three ports, allows one outstanding transaction, and routes the response back to the master that owns it. It sits between the control unit/datapath and a unified memory, and includes a response watchdog.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles from grant to r_valid before the transaction is aborted; must be ≥ 2

Ports:
- CLK  in  1  clock, rising edge
- RES  in  1  one clock; reset is synchronous and active-low
- instr_req  in  1  fetch request
- instr_addr  in  ADDR_W  fetch address
- instr_gnt  out  1  fetch request accepted
- instr_r_valid  out  1  fetch data valid
- instr_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_addr  in  ADDR_W  data address
- data_write_enable  in  1  1 = write, 0 = read
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  data request accepted
- data_r_valid  out  1  read data valid, or write complete
- data_rdata  out  DATA_W  load data
- mem_req / mem_addr / mem_we / mem_wdata  out  1/ADDR_W/1/DATA_W  slave request
- mem_gnt  in  1  slave accepts request
- mem_r_valid  in  1  slave response; asserted for reads and writes
- mem_rdata  in  DATA_W  slave read data
- err  out  1  one-cycle pulse on watchdog abort

## Operation
States:
- IDLE
- BUSY_I (fetch outstanding)
- BUSY_D (data outstanding)

IDLE:
- Winner is chosen combinationally from the current requests.
- mem_req = winner's req. mem_addr, mem_we and mem_wdata come from the winner; instruction fetches drive mem_we = 0 and mem_wdata = 0.
- The winner's gnt = mem_gnt. The loser's gnt = 0.
- On mem_gnt: latch the owner, clear the watchdog counter, go to BUSY_I or BUSY_D.
- A master may drop req before it is granted. Nothing is latched, and the mux follows the new winner.

BUSY_x:
- mem_req = 0 and both gnt = 0. New requests wait.
- The owner's r_valid = mem_r_valid. The other master's r_valid = 0.
- On mem_r_valid, return to IDLE. The next grant is possible one cycle later (a one-cycle bubble).
- The counter increments every cycle. If it reaches TIMEOUT with no mem_r_valid: pulse err, return to IDLE, and forward no r_valid for that transaction.

Other rules:
- instr_rdata and data_rdata = mem_rdata at all times. Only r_valid is gated.
- mem_r_valid in IDLE is ignored and is not forwarded.
- Default arbitration: fixed priority, data over instruction. A load/store holds the fetch off until it completes.

## Timing
- Reset (RES low at a CLK edge): state IDLE, counter 0, round-robin pointer = prefer-instruction. Registered err = 0. With no requests driven, all outputs are 0.
- Reset mid-transaction: the transaction is abandoned. No r_valid is forwarded after reset, and a late mem_r_valid is ignored.
- Grant: combinational, same cycle as mem_gnt. Zero added request latency.
- Response path: combinational pass-through. Zero added latency.
- Throughput: one transaction per (slave latency + 1) cycles, at most.
- Simultaneous mem_gnt and mem_r_valid in IDLE: the grant is taken, and the r_valid is ignored.
- Slave rule: mem_r_valid no earlier than one cycle after mem_gnt.
- err is registered and asserts in the cycle after the counter reaches TIMEOUT.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A 1-bit pointer updates on each grant to prefer the other master.
  - With both masters requesting, grants alternate D, I, D, I.
  - A single requester is always served.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data over instruction. There is no pointer register.

## Test plan
- Fetch only:
  - Stimulus: instr_req=1, instr_addr=0x100; slave grants immediately and returns r_valid 2 cycles later with 0x00500093.
  - Response: instr_gnt in the same cycle; instr_r_valid=1 with instr_rdata=0x00500093; data_r_valid stays 0.
- Contention, fixed priority:
  - Stimulus: instr_req and data_req both 1 in the same cycle; data is a read of 0x200 returning 0xDEADBEEF.
  - Response: data_gnt first, instr_gnt=0. After data_r_valid, instr_gnt comes one cycle later.
- Round-robin (macro defined):
  - Stimulus: both masters hold req for 4 transactions.
  - Response: grant order D, I, D, I.
- Store:
  - Stimulus: data_write_enable=1, addr 0x300, wdata 0x12345678.
  - Response: mem_we=1, mem_wdata=0x12345678; data_r_valid on the slave's completion.
- Watchdog:
  - Stimulus: TIMEOUT=8, slave never asserts r_valid.
  - Response: err pulses once, the FSM returns to IDLE, and the next request is granted.
- Reset mid-operation:
  - Stimulus: RES low while in BUSY_D, then mem_r_valid after RES returns high.
  - Response: data_r_valid stays 0; all outputs are 0 through reset.
